seq_run_controller: RTL and testbench

- Sequencing controller for the 4-bit custom-sequence counter: 0000->1101->1011->1001->0110->1100->0011->1111->0000.
- Owns the sequence register and advances it under control: free-run with programmable prescale, single-step, stop, run-to-target halt, and parallel load with illegal-code recovery.
- Sits between front-panel/test control logic and any consumer of the sequence value.

---
 rtl/seq_pkg.sv | 53 +++++
 rtl/seq_next_lut.sv | 25 ++
 rtl/seq_run_controller.sv | 150 +++++++++++++++
 tb/tb_seq_run_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared types, code table and helpers for the custom-sequence counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

  localparam int SEQ_LEN = 8;
  localparam int CODE_W  = 4;
  localparam int IDX_W   = 3;

  // Codes listed in advance order; the array index is the position.
  localparam logic [CODE_W-1:0] SEQ_CODES [SEQ_LEN] = '{
    4'b0000, 4'b1101, 4'b1011, 4'b1001,
    4'b0110, 4'b1100, 4'b0011, 4'b1111
  };

  function automatic logic code_legal(input logic [CODE_W-1:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (SEQ_CODES[i] == code) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [IDX_W-1:0] code_index(input logic [CODE_W-1:0] code);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (SEQ_CODES[i] == code) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Unused codes map to 0000 so an illegal value can never stall the counter.
  function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] code);
    logic [IDX_W-1:0] nidx;
    nidx = code_index(code) + IDX_W'(1);
    return code_legal(code) ? SEQ_CODES[nidx] : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_next_lut.sv
// ============================================================================
// Module   : seq_next_lut
// Brief    : Combinational successor / index / legality lookup for one code.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_next_lut
  import seq_pkg::*;
(
  input  logic [3:0] q,
  output logic [3:0] next_q,
  output logic [2:0] idx,
  output logic       legal
);

  always_comb begin
    next_q = next_code(q);
    idx    = code_index(q);
    legal  = code_legal(q);
  end

endmodule

`default_nettype wire

// File: rtl/seq_run_controller.sv
// ============================================================================
// Module   : seq_run_controller
// Brief    : Run/step/stop/load/target-halt controller owning the sequence register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_run_controller
  import seq_pkg::*;
#(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic                  load,
  input  logic [3:0]            load_val,
  input  logic                  target_en,
  input  logic [3:0]            target,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [3:0]            q,
  output logic [2:0]            pos,
  output logic                  busy,
  output logic                  halted,
  output logic                  done,
  output logic                  wrap,
  output logic                  err
);

  seq_state_t            r_state, w_state_nxt;
  logic [PRESCALE_W-1:0] r_div, w_div_nxt;
  logic [3:0]            r_q, w_q_nxt;
  logic [2:0]            r_pos, w_pos_nxt;
  logic                  r_busy, r_halted, r_done, r_wrap, r_err;
  logic                  w_done_nxt, w_wrap_nxt, w_err_nxt;

  logic [3:0] w_adv_next;
  logic [2:0] w_adv_idx;
  logic       w_adv_legal;
  logic [3:0] w_ld_next_unused;
  logic [2:0] w_ld_idx;
  logic       w_ld_legal;
  logic [3:0] w_step_q;
  logic [2:0] w_step_pos;
  logic       w_step_wrap;

  seq_next_lut u_adv_lut (
    .q      (r_q),
    .next_q (w_adv_next),
    .idx    (w_adv_idx),
    .legal  (w_adv_legal)
  );

  seq_next_lut u_ld_lut (
    .q      (load_val),
    .next_q (w_ld_next_unused),
    .idx    (w_ld_idx),
    .legal  (w_ld_legal)
  );

  // Common advance result shared by RUN ticks and single steps.
  assign w_step_q    = w_adv_next;
  assign w_step_pos  = w_adv_idx + 3'd1;
  assign w_step_wrap = w_adv_legal && (w_adv_next == 4'b0000);

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_q_nxt     = r_q;
    w_pos_nxt   = r_pos;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    if (load) begin
      w_state_nxt = ST_IDLE;
      w_div_nxt   = '0;
      if (w_ld_legal) begin
        w_q_nxt   = load_val;
        w_pos_nxt = w_ld_idx;
      end else begin
        w_q_nxt   = 4'b0000;
        w_pos_nxt = 3'd0;
        w_err_nxt = 1'b1;
      end
    end else if (stop) begin
      w_state_nxt = ST_IDLE;
      w_div_nxt   = '0;
    end else if (start && (r_state != ST_RUN)) begin
      w_state_nxt = ST_RUN;
      w_div_nxt   = '0;
    end else if (r_state == ST_RUN) begin
      // Compare with >= so a lowered prescale forces a prompt tick.
      if (r_div >= prescale) begin
        w_div_nxt  = '0;
        w_q_nxt    = w_step_q;
        w_pos_nxt  = w_step_pos;
        w_wrap_nxt = w_step_wrap;
        if (target_en && (w_step_q == target)) begin
          w_state_nxt = ST_HALT;
          w_done_nxt  = 1'b1;
        end
      end else begin
        w_div_nxt = r_div + PRESCALE_W'(1);
      end
    end else if (step) begin
      w_state_nxt = ST_IDLE;
      w_q_nxt     = w_step_q;
      w_pos_nxt   = w_step_pos;
      w_wrap_nxt  = w_step_wrap;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state  <= ST_IDLE;
      r_div    <= '0;
      r_q      <= 4'b0000;
      r_pos    <= 3'd0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_q      <= w_q_nxt;
      r_pos    <= w_pos_nxt;
      r_busy   <= (w_state_nxt == ST_RUN);
      r_halted <= (w_state_nxt == ST_HALT);
      r_done   <= w_done_nxt;
      r_wrap   <= w_wrap_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign q      = r_q;
  assign pos    = r_pos;
  assign busy   = r_busy;
  assign halted = r_halted;
  assign done   = r_done;
  assign wrap   = r_wrap;
  assign err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_seq_run_controller.sv
// ============================================================================
// Module   : tb_seq_run_controller
// Brief    : Directed self-checking bench for seq_run_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_run_controller;

  logic       clk;
  logic       clear;
  logic       start, stop, step, load, target_en;
  logic [3:0] load_val, target, prescale;
  logic [3:0] q;
  logic [2:0] pos;
  logic       busy, halted, done, wrap, err;

  int n_checks = 0;
  int n_errors = 0;

  seq_run_controller #(.PRESCALE_W(4)) dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .load      (load),
    .load_val  (load_val),
    .target_en (target_en),
    .target    (target),
    .prescale  (prescale),
    .q         (q),
    .pos       (pos),
    .busy      (busy),
    .halted    (halted),
    .done      (done),
    .wrap      (wrap),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  logic [3:0] exp_q   [9] = '{4'hD, 4'hB, 4'h9, 4'h6, 4'hC, 4'h3, 4'hF, 4'h0, 4'hD};
  logic [2:0] exp_pos [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

  initial begin
    int cnt;
    int hsum;
    clear = 1'b0;
    start = 0; stop = 0; step = 0; load = 0; target_en = 0;
    load_val = 4'h0; target = 4'h0; prescale = 4'h0;
    repeat (3) cyc();
    check_val("rst_q", 8'(q), 8'h0);
    check_val("rst_pos", 8'(pos), 8'h0);
    check_val("rst_flags", {2'b0, busy, halted, done, wrap, err, 1'b0}, 8'h0);
    clear = 1'b1;
    cyc();

    // Free-run at prescale 0 across the wrap
    do_start();
    check_val("run_busy", 8'(busy), 8'h1);
    check_val("run_q0", 8'(q), 8'h0);
    for (int i = 0; i < 9; i++) begin
      cyc();
      check_val($sformatf("walk_q%0d", i), 8'(q), 8'(exp_q[i]));
      check_val($sformatf("walk_pos%0d", i), 8'(pos), 8'(exp_pos[i]));
      check_val($sformatf("walk_wrap%0d", i), 8'(wrap), (i == 7) ? 8'h1 : 8'h0);
    end

    // Stop while a tick is due: q must hold
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check_val("stop_q", 8'(q), 8'hD);
    check_val("stop_busy", 8'(busy), 8'h0);

    // Prescale 3: change every 4th cycle
    do_load(4'h0);
    prescale = 4'd3;
    do_start();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check_val($sformatf("ps_q%0d", k), 8'(q), (k < 4) ? 8'h0 : ((k < 8) ? 8'hD : 8'hB));
      check_val($sformatf("ps_busy%0d", k), 8'(busy), 8'h1);
    end
    stop = 1'b1; cyc(); stop = 1'b0;

    // Run-to-target halt and restart
    do_load(4'h0);
    prescale = 4'd0; target_en = 1'b1; target = 4'b0110;
    do_start();
    repeat (4) cyc();
    check_val("tgt_q", 8'(q), 8'h6);
    check_val("tgt_pos", 8'(pos), 8'h4);
    check_val("tgt_done", 8'(done), 8'h1);
    check_val("tgt_halted", 8'(halted), 8'h1);
    check_val("tgt_busy", 8'(busy), 8'h0);
    cyc();
    check_val("tgt_done_pulse", 8'(done), 8'h0);
    check_val("tgt_hold", 8'(q), 8'h6);
    do_start();
    check_val("restart_busy", 8'(busy), 8'h1);
    cnt = 0;
    while (!halted && cnt < 20) begin
      cyc();
      cnt++;
    end
    check_val("restart_adv", 8'(cnt), 8'd8);
    check_val("restart_q", 8'(q), 8'h6);
    check_val("restart_done", 8'(done), 8'h1);

    // Illegal target never halts
    do_load(4'h0);
    target = 4'b0101;
    do_start();
    hsum = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      hsum += int'(halted) + int'(done);
    end
    check_val("illtgt_halt", 8'(hsum), 8'h0);
    check_val("illtgt_busy", 8'(busy), 8'h1);
    target_en = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;

    // Loads and step in IDLE
    do_load(4'b1001);
    check_val("ld_q", 8'(q), 8'h9);
    check_val("ld_pos", 8'(pos), 8'h3);
    check_val("ld_err", 8'(err), 8'h0);
    do_load(4'b0101);
    check_val("ldbad_q", 8'(q), 8'h0);
    check_val("ldbad_pos", 8'(pos), 8'h0);
    check_val("ldbad_err", 8'(err), 8'h1);
    step = 1'b1; cyc(); step = 1'b0;
    check_val("err_pulse", 8'(err), 8'h0);
    check_val("step_q", 8'(q), 8'hD);
    check_val("step_pos", 8'(pos), 8'h1);
    check_val("step_done", 8'(done), 8'h0);
    check_val("step_busy", 8'(busy), 8'h0);
    do_load(4'b1111);
    check_val("ldf_wrap", 8'(wrap), 8'h0);
    step = 1'b1; cyc(); step = 1'b0;
    check_val("stepwrap_q", 8'(q), 8'h0);
    check_val("stepwrap_wrap", 8'(wrap), 8'h1);

    // Load beats start while running
    do_start();
    repeat (2) cyc();
    load = 1'b1; start = 1'b1; load_val = 4'b1011;
    cyc();
    load = 1'b0; start = 1'b0;
    check_val("ldstart_q", 8'(q), 8'hB);
    check_val("ldstart_pos", 8'(pos), 8'h2);
    check_val("ldstart_busy", 8'(busy), 8'h0);
    cyc();
    check_val("ldstart_idle", 8'(q), 8'hB);

    // Async clear mid-run at 0011
    do_load(4'h0);
    do_start();
    repeat (6) cyc();
    check_val("pre_clr_q", 8'(q), 8'h3);
    clear = 1'b0;
    #2;
    check_val("clr_q", 8'(q), 8'h0);
    check_val("clr_pos", 8'(pos), 8'h0);
    check_val("clr_flags", {2'b0, busy, halted, done, wrap, err, 1'b0}, 8'h0);
    @(negedge clk);
    clear = 1'b1;
    repeat (3) cyc();
    check_val("post_clr_q", 8'(q), 8'h0);
    check_val("post_clr_busy", 8'(busy), 8'h0);
    do_start();
    check_val("post_clr_start", 8'(busy), 8'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
